// File: rtl/doorlock_pkg.sv
// Shared encodings and default constants for the doorlock keypad path.
package doorlock_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned DIGIT_LIMIT = 10;
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned STATE_W     = 3;

    localparam int unsigned DEF_PW_LEN         = 4;
    localparam int unsigned DEF_MAX_ERR        = 3;
    localparam int unsigned DEF_OPEN_CYCLES    = 50;
    localparam int unsigned DEF_LOCK_CYCLES    = 300;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } state_e;

    // Largest of three durations, used to size the shared timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/doorlock_ctrl_if.sv
// Keypad-side inputs and status outputs of the doorlock sequencer.
interface doorlock_ctrl_if;
    import doorlock_pkg::*;

    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               confirm;
    logic               long_confirm;
    logic               door_open;
    logic               fail;
    logic               locked_out;
    logic               prog_mode;
    logic [ERR_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   entry_cnt;
    logic [STATE_W-1:0] state_o;

    modport master (
        output digit_valid, digit, confirm, long_confirm,
        input  door_open, fail, locked_out, prog_mode, err_cnt, entry_cnt, state_o
    );

    modport slave (
        input  digit_valid, digit, confirm, long_confirm,
        output door_open, fail, locked_out, prog_mode, err_cnt, entry_cnt, state_o
    );

endinterface

// File: rtl/doorlock_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module doorlock_ctrl_cycle_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Doorlock keypad sequencer: code entry, compare, door release, failure
// lockout and code programming.
// Optional: define ENTRY_TIMEOUT_EN to abandon idle ENTRY/PROG sessions.
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int unsigned PW_LEN                    = DEF_PW_LEN,
    parameter int unsigned MAX_ERR                   = DEF_MAX_ERR,
    parameter int unsigned OPEN_CYCLES               = DEF_OPEN_CYCLES,
    parameter int unsigned LOCK_CYCLES               = DEF_LOCK_CYCLES,
    parameter logic [PW_LEN*DIGIT_W-1:0] DEFAULT_PW  = 16'h1234,
    parameter int unsigned TIMEOUT_CYCLES            = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    doorlock_ctrl_if.slave bus
);

    localparam int unsigned PW_W  = PW_LEN * DIGIT_W;
    localparam int unsigned TMR_W = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES) + 1);

    state_e             state_q;
    logic [PW_W-1:0]    buf_q;
    logic [PW_W-1:0]    code_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   entry_cnt_q;
    logic [ERR_W-1:0]   err_q;
    logic               door_open_q;
    logic               fail_q;
    logic               locked_q;
    logic               prog_q;

    logic               lc_c, cf_c, dg_c, dg_ok_c;
    logic               room_c, full_ok_c, match_c;
    logic [PW_W-1:0]    buf_shift_c;
    logic [ERR_W-1:0]   err_inc_c;
    logic               tmr_load_c;
    logic [TMR_W-1:0]   tmr_val_c;
    logic               tmr_expired;

    // Input priority: long_confirm over confirm over digit_valid.
    assign lc_c        = bus.long_confirm;
    assign cf_c        = bus.confirm && !bus.long_confirm;
    assign dg_c        = bus.digit_valid && !bus.confirm && !bus.long_confirm;
    assign dg_ok_c     = dg_c && (bus.digit < DIGIT_W'(DIGIT_LIMIT));
    assign room_c      = entry_cnt_q < CNT_W'(PW_LEN);
    assign full_ok_c   = (entry_cnt_q == CNT_W'(PW_LEN)) && !ovf_q;
    assign match_c     = full_ok_c && (buf_q == code_q);
    assign buf_shift_c = PW_W'(buf_q << DIGIT_W) | PW_W'(bus.digit);
    assign err_inc_c   = (err_q == ERR_W'(MAX_ERR)) ? err_q : err_q + ERR_W'(1);

    // Timer reloads on entry to timed states (and on activity when timeout is on).
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state_q)
`ifdef ENTRY_TIMEOUT_EN
            ST_IDLE: begin
                if (dg_ok_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_OPEN: begin
                if (lc_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_PROG: begin
                if (dg_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
            end
`endif
            ST_ENTRY: begin
                if (cf_c && match_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(OPEN_CYCLES - 1);
                end
`ifdef ENTRY_TIMEOUT_EN
                if (dg_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(TIMEOUT_CYCLES - 1);
                end
`endif
            end
            ST_FAIL: begin
                if (err_q == ERR_W'(MAX_ERR)) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TMR_W'(LOCK_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    doorlock_ctrl_cycle_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expired  (tmr_expired)
    );

    // Main sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            code_q      <= DEFAULT_PW;
            ovf_q       <= 1'b0;
            entry_cnt_q <= '0;
            err_q       <= '0;
            door_open_q <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
            prog_q      <= 1'b0;
        end else begin
            fail_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lc_c) begin
                        state_q <= ST_IDLE;
                    end else if (cf_c) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                        err_q   <= err_inc_c;
                    end else if (dg_ok_c) begin
                        buf_q       <= PW_W'(bus.digit);
                        entry_cnt_q <= CNT_W'(1);
                        state_q     <= ST_ENTRY;
                    end
                end
                ST_ENTRY, ST_PROG: begin
                    if (lc_c || cf_c) begin
                        buf_q       <= '0;
                        entry_cnt_q <= '0;
                        ovf_q       <= 1'b0;
                        prog_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                        if (cf_c && state_q == ST_PROG && full_ok_c) begin
                            code_q <= buf_q;
                        end else if (cf_c && state_q == ST_ENTRY) begin
                            if (match_c) begin
                                state_q     <= ST_OPEN;
                                door_open_q <= 1'b1;
                                err_q       <= '0;
                            end else begin
                                state_q <= ST_FAIL;
                                fail_q  <= 1'b1;
                                err_q   <= err_inc_c;
                            end
                        end
                    end else if (dg_c) begin
                        if (dg_ok_c) begin
                            if (room_c) begin
                                buf_q       <= buf_shift_c;
                                entry_cnt_q <= entry_cnt_q + CNT_W'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
`ifdef ENTRY_TIMEOUT_EN
                    end else if (tmr_expired) begin
                        buf_q       <= '0;
                        entry_cnt_q <= '0;
                        ovf_q       <= 1'b0;
                        prog_q      <= 1'b0;
                        state_q     <= ST_IDLE;
`endif
                    end
                end
                ST_OPEN: begin
                    if (lc_c) begin
                        door_open_q <= 1'b0;
                        prog_q      <= 1'b1;
                        state_q     <= ST_PROG;
                    end else if (tmr_expired) begin
                        door_open_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    if (err_q == ERR_W'(MAX_ERR)) begin
                        locked_q <= 1'b1;
                        state_q  <= ST_LOCKOUT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_expired) begin
                        locked_q <= 1'b0;
                        err_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.door_open  = door_open_q;
    assign bus.fail       = fail_q;
    assign bus.locked_out = locked_q;
    assign bus.prog_mode  = prog_q;
    assign bus.err_cnt    = err_q;
    assign bus.entry_cnt  = entry_cnt_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed self-checking bench for doorlock_ctrl (default parameters).
module tb_doorlock_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;
    int   n;

    doorlock_ctrl_if dl ();

    doorlock_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus tasks are entered and left on a falling edge.
    task automatic pulse_digit(input logic [3:0] d);
        dl.digit_valid = 1'b1;
        dl.digit       = d;
        @(negedge clk);
        dl.digit_valid = 1'b0;
        dl.digit       = 4'd0;
    endtask

    task automatic pulse_confirm();
        dl.confirm = 1'b1;
        @(negedge clk);
        dl.confirm = 1'b0;
    endtask

    task automatic pulse_long();
        dl.long_confirm = 1'b1;
        @(negedge clk);
        dl.long_confirm = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        pulse_digit(a);
        pulse_digit(b);
        pulse_digit(c);
        pulse_digit(d);
    endtask

    task automatic wait_closed();
        for (int i = 0; i < 60; i++) begin
            if (!dl.door_open) break;
            @(negedge clk);
        end
        chk("door_closed", 32'(dl.door_open), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        rst_n    = 1'b0;
        dl.digit_valid  = 1'b0;
        dl.digit        = 4'd0;
        dl.confirm      = 1'b0;
        dl.long_confirm = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_state", 32'(dl.state_o), 32'd0);
        chk("rst_door", 32'(dl.door_open), 32'd0);
        chk("rst_err", 32'(dl.err_cnt), 32'd0);
        chk("rst_entry", 32'(dl.entry_cnt), 32'd0);
        chk("rst_lock", 32'(dl.locked_out), 32'd0);
        chk("rst_prog", 32'(dl.prog_mode), 32'd0);
        chk("rst_fail", 32'(dl.fail), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct code opens the door for 50 cycles.
        pulse_digit(4'd1);
        chk("entry_state", 32'(dl.state_o), 32'd1);
        chk("entry_cnt1", 32'(dl.entry_cnt), 32'd1);
        pulse_digit(4'd2);
        pulse_digit(4'd3);
        pulse_digit(4'd4);
        chk("entry_cnt4", 32'(dl.entry_cnt), 32'd4);
        pulse_confirm();
        chk("open_door", 32'(dl.door_open), 32'd1);
        chk("open_state", 32'(dl.state_o), 32'd2);
        chk("open_err", 32'(dl.err_cnt), 32'd0);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dl.door_open) n++;
            else break;
        end
        chk("open_len", 32'(n), 32'd50);
        chk("open_exit_state", 32'(dl.state_o), 32'd0);

        // Three wrong codes lead to lockout.
        for (int a = 1; a <= 3; a++) begin
            enter4(4'd1, 4'd2, 4'd3, 4'd5);
            pulse_confirm();
            chk("bad_fail", 32'(dl.fail), 32'd1);
            chk("bad_err", 32'(dl.err_cnt), 32'(a));
            chk("bad_door", 32'(dl.door_open), 32'd0);
            @(negedge clk);
            chk("bad_fail_1cyc", 32'(dl.fail), 32'd0);
            chk("bad_next_state", 32'(dl.state_o), (a == 3) ? 32'd4 : 32'd0);
        end
        chk("lock_on", 32'(dl.locked_out), 32'd1);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            if (i == 10) begin dl.digit_valid = 1'b1; dl.digit = 4'd1; end
            if (i == 11) begin dl.digit_valid = 1'b0; dl.digit = 4'd0; end
            if (i == 20) dl.confirm = 1'b1;
            if (i == 21) dl.confirm = 1'b0;
            @(negedge clk);
            if (i == 12) begin
                chk("lock_digit_ign", 32'(dl.entry_cnt), 32'd0);
                chk("lock_state", 32'(dl.state_o), 32'd4);
            end
            if (dl.locked_out) n++;
            else break;
        end
        chk("lock_len", 32'(n), 32'd300);
        chk("lock_exit_err", 32'(dl.err_cnt), 32'd0);
        chk("lock_exit_state", 32'(dl.state_o), 32'd0);

        // Overflow, short entry and invalid digits.
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_digit(4'd5);
        chk("ovf_cnt", 32'(dl.entry_cnt), 32'd4);
        pulse_confirm();
        chk("ovf_fail", 32'(dl.fail), 32'd1);
        chk("ovf_err", 32'(dl.err_cnt), 32'd1);
        @(negedge clk);
        pulse_digit(4'd1);
        pulse_digit(4'd2);
        pulse_confirm();
        chk("short_fail", 32'(dl.fail), 32'd1);
        chk("short_err", 32'(dl.err_cnt), 32'd2);
        @(negedge clk);
        pulse_digit(4'd11);
        chk("inv_idle_state", 32'(dl.state_o), 32'd0);
        chk("inv_idle_cnt", 32'(dl.entry_cnt), 32'd0);
        pulse_digit(4'd1);
        pulse_digit(4'd11);
        chk("inv_entry_cnt", 32'(dl.entry_cnt), 32'd1);
        pulse_long();
        chk("cancel_state", 32'(dl.state_o), 32'd0);
        chk("cancel_cnt", 32'(dl.entry_cnt), 32'd0);
        chk("cancel_err", 32'(dl.err_cnt), 32'd2);

        // Program a new code while open.
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_confirm();
        chk("reopen_door", 32'(dl.door_open), 32'd1);
        chk("reopen_err", 32'(dl.err_cnt), 32'd0);
        repeat (3) @(negedge clk);
        pulse_long();
        chk("prog_mode", 32'(dl.prog_mode), 32'd1);
        chk("prog_door", 32'(dl.door_open), 32'd0);
        chk("prog_state", 32'(dl.state_o), 32'd5);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        chk("prog_cnt", 32'(dl.entry_cnt), 32'd4);
        pulse_confirm();
        chk("prog_exit_state", 32'(dl.state_o), 32'd0);
        chk("prog_exit_mode", 32'(dl.prog_mode), 32'd0);
        chk("prog_exit_fail", 32'(dl.fail), 32'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_confirm();
        chk("old_code_fail", 32'(dl.fail), 32'd1);
        chk("old_code_door", 32'(dl.door_open), 32'd0);
        @(negedge clk);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        pulse_confirm();
        chk("new_code_door", 32'(dl.door_open), 32'd1);
        chk("new_code_err", 32'(dl.err_cnt), 32'd0);
        wait_closed();

        // Reset restores the default code; async reset drops the door.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_confirm();
        chk("default_code_door", 32'(dl.door_open), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_door", 32'(dl.door_open), 32'd0);
        chk("async_rst_state", 32'(dl.state_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All three inputs together: long_confirm wins.
        pulse_digit(4'd1);
        pulse_digit(4'd2);
        dl.digit_valid  = 1'b1;
        dl.digit        = 4'd3;
        dl.confirm      = 1'b1;
        dl.long_confirm = 1'b1;
        @(negedge clk);
        dl.digit_valid  = 1'b0;
        dl.digit        = 4'd0;
        dl.confirm      = 1'b0;
        dl.long_confirm = 1'b0;
        chk("all3_state", 32'(dl.state_o), 32'd0);
        chk("all3_cnt", 32'(dl.entry_cnt), 32'd0);
        chk("all3_fail", 32'(dl.fail), 32'd0);
        chk("all3_err", 32'(dl.err_cnt), 32'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        pulse_confirm();
        chk("all3_then_open", 32'(dl.door_open), 32'd1);
        wait_closed();

        // Entry inactivity.
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        pulse_confirm();
        @(negedge clk);
        chk("pre_to_err", 32'(dl.err_cnt), 32'd1);
        pulse_digit(4'd5);
        chk("to_entry", 32'(dl.state_o), 32'd1);
`ifdef ENTRY_TIMEOUT_EN
        repeat (199) @(negedge clk);
        chk("to_not_yet", 32'(dl.state_o), 32'd1);
        @(negedge clk);
        chk("to_state", 32'(dl.state_o), 32'd0);
        chk("to_cnt", 32'(dl.entry_cnt), 32'd0);
        chk("to_err", 32'(dl.err_cnt), 32'd1);
        chk("to_fail", 32'(dl.fail), 32'd0);
`else
        repeat (1000) @(negedge clk);
        chk("noto_state", 32'(dl.state_o), 32'd1);
        chk("noto_cnt", 32'(dl.entry_cnt), 32'd1);
        pulse_long();
        chk("noto_cancel", 32'(dl.state_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
